// File: rtl/spi_ctrl_pkg.sv
// Shared opcode constants and the command-sequencer state encoding.
package spi_ctrl_pkg;

    localparam logic [3:0] OP_WRITE     = 4'h1;
    localparam logic [3:0] OP_WRITE_INC = 4'h2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        DATA   = 2'd2,
        DROP   = 2'd3
    } state_t;

endpackage

// File: rtl/spi_cmd_ctrl_if.sv
// Write-bus handshake. wr_valid/wr_ready: a transfer happens in every cycle where both are high;
// wr_addr/wr_data stay stable while wr_valid is high and the transfer has not happened.
interface spi_cmd_ctrl_if #(
    parameter int width      = 16,
    parameter int addr_width = 8
);
    logic                  wr_valid;
    logic                  wr_ready;
    logic [addr_width-1:0] wr_addr;
    logic [width-1:0]      wr_data;

    modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/spi_wr_slot.sv
// One-entry write holding register: loads when free or draining this cycle, else flags overrun.
module spi_wr_slot #(
    parameter int width      = 16,
    parameter int addr_width = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_req,
    input  logic [addr_width-1:0] load_addr,
    input  logic [width-1:0]      load_data,
    output logic                  load,
    output logic                  overrun,
    spi_cmd_ctrl_if.master        bus
);
    logic                  valid_q;
    logic [addr_width-1:0] addr_q;
    logic [width-1:0]      data_q;
    logic                  accept;
    logic                  free;

    assign accept  = valid_q && bus.wr_ready;
    assign free    = !valid_q || accept;
    assign load    = load_req && free;
    assign overrun = load_req && !free;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            addr_q  <= load_addr;
            data_q  <= load_data;
        end else if (accept) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.wr_valid = valid_q;
    assign bus.wr_addr  = addr_q;
    assign bus.wr_data  = data_q;
endmodule

// File: rtl/spi_cmd_ctrl.sv
// Frame parser: header word selects opcode/address, data words become bus writes.
module spi_cmd_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int width      = 16,
    parameter int addr_width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             new_transfer,
    input  logic             transfer_done,
    input  logic             data_ready,
    input  logic [width-1:0] rx_word,
    spi_cmd_ctrl_if.master   bus,
    output logic [7:0]       frame_count,
    output logic             err_opcode,
    output logic             err_overrun,
    input  logic             clear_err,
    output state_t           dbg_state
);
    state_t                state_q, state_d, state_after;
    logic [addr_width-1:0] addr_q;
    logic                  mode_inc_q;
    logic                  hdr_load, op_err, load_req, count_inc;
    logic                  slot_load, slot_overrun;
    logic [3:0]            opcode;

    assign opcode = rx_word[width-1 -: 4];

    always_comb begin
        state_d     = state_q;
        state_after = state_q;
        hdr_load    = 1'b0;
        op_err      = 1'b0;
        load_req    = 1'b0;
        count_inc   = 1'b0;
        if (new_transfer) begin
            state_d = HEADER;
        end else begin
            case (state_q)
                HEADER: if (data_ready) begin
                    if (opcode == OP_WRITE || opcode == OP_WRITE_INC) begin
                        hdr_load    = 1'b1;
                        state_after = DATA;
                    end else begin
                        op_err      = 1'b1;
                        state_after = DROP;
                    end
                end
                DATA:    load_req = data_ready;
                default: ;
            endcase
            state_d = state_after;
            // The word arriving with nCS rising is handled first, so a frame that just entered DATA counts.
            if (transfer_done) begin
                state_d   = IDLE;
                count_inc = (state_after == DATA);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            mode_inc_q  <= 1'b0;
            frame_count <= '0;
            err_opcode  <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            state_q <= state_d;
            if (hdr_load) begin
                addr_q     <= rx_word[addr_width-1:0];
                mode_inc_q <= (opcode == OP_WRITE_INC);
            end else if (slot_load && mode_inc_q) begin
                addr_q <= addr_q + 1'b1;
            end
            if (count_inc) frame_count <= frame_count + 8'd1;
            err_opcode  <= op_err || (err_opcode && !clear_err);
            err_overrun <= slot_overrun || (err_overrun && !clear_err);
        end
    end

    spi_wr_slot #(.width(width), .addr_width(addr_width)) u_slot (
        .clk       (clk),
        .reset     (reset),
        .load_req  (load_req),
        .load_addr (addr_q),
        .load_data (rx_word),
        .load      (slot_load),
        .overrun   (slot_overrun),
        .bus       (bus)
    );

    assign dbg_state = state_q;
endmodule

// File: doc/spi_cmd_ctrl.md
# spi_cmd_ctrl

Command sequencer behind the `spi` receive slave. It parses each chip-select frame as one header word followed by data words. It converts the data words into valid/ready write transactions on the internal register/memory bus, in fixed-address or auto-increment mode. It also keeps a frame counter and sticky error flags for the host to poll.

## Interface
Parameters:
- `width`, 16, SPI word width; must match the `spi` instance.
- `addr_width`, 8, bus address width; legal range 1 to `width`-4.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `new_transfer`  in  1  one-cycle pulse from `spi` on nCS falling.
- `transfer_done`  in  1  one-cycle pulse from `spi` on nCS rising.
- `data_ready`  in  1  one-cycle pulse from `spi`; `rx_word` is valid in that cycle.
- `rx_word`  in  `width`  `spi` shift register.
- `wr_valid`  out  1  write request pending.
- `wr_ready`  in  1  bus accepts the write.
- `wr_addr`  out  `addr_width`  write address.
- `wr_data`  out  `width`  write data.
- `frame_count`  out  8  number of completed legal frames, wraps at 256.
- `err_opcode`  out  1  sticky: illegal header seen.
- `err_overrun`  out  1  sticky: data word lost because a write was still pending.
- `clear_err`  in  1  pulse that clears both error flags.

## Operation
Header word format:
- opcode = `rx_word[width-1:width-4]`.
- address = `rx_word[addr_width-1:0]`.
- Remaining bits are ignored.

Opcodes:
- 4'h1 WRITE: every data word goes to the header address.
- 4'h2 WRITE_INC: address increments after each loaded word and wraps modulo 2^`addr_width`.
- Any other opcode is illegal.

States: IDLE, HEADER, DATA, DROP.
- Any state, `new_transfer` → HEADER. This aborts a frame in progress. `new_transfer` has priority over every other input in that cycle.
- Any state, `transfer_done` → IDLE. A `data_ready` in the same cycle is processed first.
- HEADER, `data_ready`:
  - Legal opcode: latch address and mode, go to DATA.
  - Illegal opcode: set `err_opcode`, go to DROP.
- DATA, `data_ready`:
  - If the write slot is free, or is being accepted this cycle (`wr_valid`&&`wr_ready`): load `rx_word` into `wr_data` and the current address into `wr_addr`, and set `wr_valid`. In WRITE_INC, the address register advances by 1.
  - Otherwise: drop the word, set `err_overrun`, and leave the pending write and the address unchanged.
- DROP, IDLE: `data_ready` is ignored.
- Frame counting: `transfer_done` while in DATA increments `frame_count`, including frames with zero data words. It does not increment while in HEADER, DROP or IDLE.

Write slot:
- A write is accepted when `wr_valid`&&`wr_ready`. `wr_valid` then clears next cycle unless a new word is loaded in the same cycle.
- The pending write survives frame end and abort, and drains normally.
- `wr_addr` and `wr_data` are stable while `wr_valid` is high and not accepted.

Error flags:
- `clear_err` clears both flags.
- If an error is set in the same cycle as `clear_err`, the set wins.

## Timing
- Reset values: state IDLE, `wr_valid`=0, `wr_addr`=0, `wr_data`=0, `frame_count`=0, `err_opcode`=0, `err_overrun`=0. The address register is also 0.
- Reset mid-frame discards the pending write immediately. The block stays idle until the next `new_transfer`.
- Latency: `data_ready` in cycle N → `wr_valid`, `wr_addr` and `wr_data` valid in cycle N+1.
- Throughput: one write per cycle is sustainable. With `wr_ready` held high, back-to-back `data_ready` never overruns.
- Counter and flag updates appear on outputs one cycle after the causing input. All outputs are registered.

## Structure
- Package `spi_ctrl_pkg` holds:
  - opcode constants `OP_WRITE`=4'h1 and `OP_WRITE_INC`=4'h2;
  - the state enumeration IDLE/HEADER/DATA/DROP.
- Natural sub-module: `spi_wr_slot`, the one-entry valid/ready holding register with load, accept and overrun-detect outputs.
- The FSM, address register, frame counter and error flags stay in `spi_cmd_ctrl`.

## Test plan
- WRITE_INC burst:
  - Stimulus: header 16'h2010, then data 16'hAAAA, 16'hBBBB, 16'hCCCC, `wr_ready`=1.
  - Required: writes (0x10,AAAA), (0x11,BBBB), (0x12,CCCC); `frame_count` 0→1 after `transfer_done`.
- WRITE fixed address with wrap check:
  - Stimulus: header 16'h10FF, then two data words.
  - Required: both writes to 0xFF, with no increment.
  - Stimulus: WRITE_INC at 0xFF with two data words.
  - Required: writes to 0xFF, then 0x00.
- Illegal opcode:
  - Stimulus: header 16'h7005, then data words.
  - Required: no `wr_valid`, `err_opcode`=1, `frame_count` unchanged.
  - Stimulus: `clear_err` pulse.
  - Required: `err_opcode`=0.
- Overrun:
  - Stimulus: `wr_ready`=0, WRITE_INC header at 0x20, data 1111 then 2222.
  - Required: `err_overrun`=1; pending stays (0x20,1111).
  - Stimulus: raise `wr_ready`.
  - Required: one write (0x20,1111) only; next data word goes to 0x21.
- Abort and reset:
  - Stimulus: `new_transfer` mid-DATA, then header 16'h2030.
  - Required: next write goes to 0x30; `frame_count` not incremented for the aborted frame.
  - Stimulus: `reset` asserted while `wr_valid`=1.
  - Required: all outputs return to zero asynchronously.
- Simultaneous events:
  - Stimulus: `clear_err` in the same cycle as an overrun.
  - Required: `err_overrun` stays 1.
  - Stimulus: `data_ready` in the same cycle as acceptance with `wr_ready`=1.
  - Required: new word loaded, no overrun.
